// File: rtl/add_serial_param.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB digit first,
// and presents the registered result with carry/no-borrow and signed overflow.
module add_serial_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sub,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned Steps = WIDTH / DIGIT;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [DIGIT:0]   sum;
  logic             last;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    last    = (count_q == CntW'(Steps - 1));

    unique case (state_q)
      StIdle: begin
        // en has priority over clr here; clr only aborts a running operation
        if (en) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          count_d = '0;
          out_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (clr) begin
          out_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = StIdle;
        end else begin
          carry_d = sum[DIGIT];
          out_d   = (out_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          count_d = count_q + CntW'(1);
          if (last) begin
            cout_d  = sum[DIGIT];
            // carry into the MSB recovered from the MSB's sum bit and its operands
            ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1] ^ sum[DIGIT];
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_add_serial_param.sv
// Directed bench for add_serial_param: bit-serial instance (DIGIT=1) plus a
// 4-bit-digit instance, table of hand-computed vectors and multi-cycle corner cases.
module tb_add_serial_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, sub = 1'b0, clr = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] out;
  logic       cout, ovf, busy, done;

  logic       en4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic [7:0] out4;
  logic       cout4, ovf4, busy4, done4;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_serial_param #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sub(sub), .clr(clr), .a(a), .b(b),
    .out(out), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  add_serial_param #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .sub(1'b0), .clr(1'b0), .a(a4), .b(b4),
    .out(out4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] eo;
    logic       ec;
    logic       ev;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation on the DIGIT=1 instance and checks latency, result and hold.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                        input logic [7:0] eo, input logic ec, input logic ev,
                        input logic with_clr, input logic poke_en);
    int lat;
    lat = 0;
    @(negedge clk);
    a = va; b = vb; sub = vs; en = 1'b1; clr = with_clr;
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_out_zero", out, 0);
    @(negedge clk);
    en = 1'b0; clr = 1'b0; a = ~va; b = ~vb; sub = ~vs;
    for (int k = 1; k <= 20; k++) begin
      if (poke_en && (k == 2 || k == 4)) begin
        @(negedge clk); en = 1'b1; a = 8'hFF; b = 8'hFF;
      end else if (poke_en && (k == 3 || k == 5)) begin
        @(negedge clk); en = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) begin
        check("busy_during_op", busy, 1);
        break;
      end
    end
    en = 1'b0;
    check("latency", lat, 8);
    check("done_busy", busy, 1);
    check("out", out, eo);
    check("cout", cout, ec);
    check("ovf", ovf, ev);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("out_hold", out, eo);
    check("cout_hold", cout, ec);
  endtask

  initial begin
    int lat;
    logic seen_done;
    tbl[0] = '{8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[9] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};

    #12;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].eo, tbl[i].ec, tbl[i].ev, 1'b0, 1'b0);
    end

    // en and clr together in IDLE: en wins
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, 1'b0);
    // en toggled while busy is ignored
    run_op(8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1);

    // clr three edges into an operation
    @(negedge clk); a = 8'h35; b = 8'h0A; sub = 1'b0; en = 1'b1;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    check("clr_busy", busy, 0);
    check("clr_out", out, 0);
    check("clr_cout", cout, 0);
    check("clr_done", done, 0);
    @(negedge clk); clr = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("clr_no_done", seen_done, 0);

    // async reset mid-ADD between edges
    run_op(8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); a = 8'hFF; b = 8'h01; en = 1'b1;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_out", out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_cout", cout, 0);
    @(negedge clk); rst = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("arst_no_done", seen_done, 0);
    run_op(8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);

    // DIGIT=4 instance: two steps
    lat = 0;
    @(negedge clk); a4 = 8'h9C; b4 = 8'h27; en4 = 1'b1;
    @(posedge clk);
    @(negedge clk); en4 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = k;
        break;
      end
    end
    check("d4_latency", lat, 2);
    check("d4_out", out4, 8'hC3);
    check("d4_cout", cout4, 0);
    check("d4_ovf", ovf4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
